vga_timing_gen: RTL

- Raster timing generator that sits directly upstream of pixel_gen.
- Produces the pixel and line counters, the h_sync/v_sync strobes, video_on and frame/line markers, all aligned on rfr_clk.
- Horizontal and vertical axes each run an explicit phase state machine (ACTIVE, FRONT, SYNC, BACK), advanced by a pixel-rate enable.
- Default timing is 640x480@60.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_timing_gen_axis.sv | 63 ++++++
 rtl/vga_timing_gen.sv | 74 +++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared raster phase type and default 640x480@60 timing constants.
package vga_pkg;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    localparam int H_TOTAL   = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL   = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int MAX_PIXEL = DEF_H_ACTIVE - 1;
    localparam int MAX_LINE  = DEF_V_ACTIVE - 1;

endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter: one raster axis - position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK,
    parameter int POL    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        adv,
    output logic [11:0] cnt,
    output phase_t      phase,
    output logic        sync,
    output logic        wrap
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [11:0] LAST    = 12'(TOTAL - 1);
    localparam logic [11:0] F_START = 12'(ACTIVE);
    localparam logic [11:0] S_START = 12'(ACTIVE + FRONT);
    localparam logic [11:0] B_START = 12'(ACTIVE + FRONT + SYNC);
    localparam logic        ON      = 1'(POL);

    if (ACTIVE <= 0 || FRONT <= 0 || SYNC <= 0 || BACK <= 0 || TOTAL > 4096) begin : g_bad_timing
        $error("vga_axis_counter: timing parameters must be nonzero with total <= 4096");
    end

    logic [11:0] cnt_nxt;
    phase_t      phase_nxt;
    logic        sync_nxt;

    assign wrap = cnt == LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= LAST;
            phase <= PH_BACK;
            sync  <= ~ON;
        end else if (adv) begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
            sync  <= sync_nxt;
        end
    end

    // phase boundaries are detected on the upcoming count so phase and count stay aligned
    always_comb begin
        cnt_nxt   = wrap ? 12'd0 : cnt + 12'd1;
        phase_nxt = phase;
        case (phase)
            PH_ACTIVE: phase_nxt = (cnt_nxt == F_START) ? PH_FRONT  : PH_ACTIVE;
            PH_FRONT:  phase_nxt = (cnt_nxt == S_START) ? PH_SYNC   : PH_FRONT;
            PH_SYNC:   phase_nxt = (cnt_nxt == B_START) ? PH_BACK   : PH_SYNC;
            PH_BACK:   phase_nxt = (cnt_nxt == 12'd0)   ? PH_ACTIVE : PH_BACK;
        endcase
    end

    always_comb sync_nxt = (phase_nxt == PH_SYNC) ? ON : ~ON;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for pixel_gen - counters, syncs, video_on and line/frame markers.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0
) (
    input  logic        rfr_clk,
    input  logic        reset_n,
    input  logic        pix_en,
    output logic [11:0] pixel_cnt,
    output logic [11:0] line_cnt,
    output logic        h_sync,
    output logic        v_sync,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam logic [11:0] H_LAST_ACT = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_LAST_ACT = 12'(V_ACTIVE - 1);

    phase_t h_phase, v_phase;
    logic   h_wrap, v_wrap, frame_wrap, h_act_nxt, v_act_nxt, started;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(H_POL)
    ) u_h (
        .clk(rfr_clk), .reset_n(reset_n), .adv(pix_en),
        .cnt(pixel_cnt), .phase(h_phase), .sync(h_sync), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(V_POL)
    ) u_v (
        .clk(rfr_clk), .reset_n(reset_n), .adv(pix_en & h_wrap),
        .cnt(line_cnt), .phase(v_phase), .sync(v_sync), .wrap(v_wrap)
    );

    // predict whether the position after this edge is visible, so video_on lines up with the counters
    always_comb begin
        frame_wrap = h_wrap && v_wrap;
        h_act_nxt  = h_wrap || (h_phase == PH_ACTIVE && pixel_cnt != H_LAST_ACT);
        v_act_nxt  = h_wrap ? (v_wrap || (v_phase == PH_ACTIVE && line_cnt != V_LAST_ACT))
                            : v_phase == PH_ACTIVE;
    end

    // started suppresses the count for the reset-release wrap so the first frame reads 0
    always_ff @(posedge rfr_clk or negedge reset_n) begin
        if (!reset_n) begin
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
            started     <= 1'b0;
        end else if (pix_en) begin
            video_on    <= h_act_nxt && v_act_nxt;
            line_start  <= h_wrap;
            frame_start <= frame_wrap;
            frame_cnt   <= frame_cnt + {7'd0, started && frame_wrap};
            started     <= 1'b1;
        end
    end

endmodule
